// File: rtl/dot_product_mac.sv
// Dot-product multiply-accumulate engine.
// Takes LEN element pairs (m, p) one per accepted cycle. Each product is
// registered, then added into a saturating accumulator. The final sum is
// presented on o with a valid/ready handshake.
module dot_product_mac #(
  parameter int unsigned W      = 10,
  parameter int unsigned LEN    = 8,
  parameter int unsigned OW     = 22,
  parameter int unsigned SIGNED = 0
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  m,
  input  logic [W-1:0]  p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] o,
  output logic          busy,
  output logic          overflow
);

  localparam int unsigned CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [2*W-1:0]  prod_q;
  logic [2*W-1:0]  prod_d;
  logic            prod_vld_q;
  logic [OW-1:0]   acc_q;
  logic [OW-1:0]   acc_d;
  logic            overflow_q;
  logic            out_valid_q;
  logic            accept;
  logic            sat;
  logic [OW-1:0]   prod_ext;
  logic [OW-1:0]   sat_val;
  logic [OW:0]     sum;
  logic [2*W-1:0]  m_ext;
  logic [2*W-1:0]  p_ext;

  assign accept    = (state_q == StAccum) && in_valid;
  assign in_ready  = (state_q == StAccum);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign o         = acc_q;

  // Multiplier: operands are extended to 2*W, so the low 2*W bits are the
  // exact product in either signedness.
  always_comb begin
    m_ext  = {{W{(SIGNED != 0) & m[W-1]}}, m};
    p_ext  = {{W{(SIGNED != 0) & p[W-1]}}, p};
    prod_d = m_ext * p_ext;
  end

  // Saturating accumulate of the registered product.
  always_comb begin
    prod_ext            = {OW{(SIGNED != 0) & prod_q[2*W-1]}};
    prod_ext[2*W-1:0]   = prod_q;
    sum = {(SIGNED != 0) & acc_q[OW-1], acc_q} +
          {(SIGNED != 0) & prod_ext[OW-1], prod_ext};
    if (SIGNED != 0) begin
      // Sign of the true sum is sum[OW]; a mismatch with sum[OW-1] means it left the range.
      sat     = sum[OW] ^ sum[OW-1];
      sat_val = sum[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else begin
      sat     = sum[OW];
      sat_val = {OW{1'b1}};
    end
    acc_d = sat ? sat_val : sum[OW-1:0];
  end

  // Control FSM, product pipeline register and accumulator.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      count_q     <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      prod_vld_q <= accept;
      if (accept) begin
        prod_q <= prod_d;
      end
      if (prod_vld_q) begin
        acc_q <= acc_d;
        if (sat) begin
          overflow_q <= 1'b1;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            count_q <= count_q + 1'b1;
            if (count_q == CW'(LEN - 1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          state_q <= StDone;
        end
        StDone: begin
          // out_valid is registered one cycle into DONE; the handshake only
          // completes once it is visible, so a result is never skipped.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// Testbench for dot_product_mac: an unsigned W=4/OW=8 instance and a signed
// W=8/OW=16 instance, both LEN=3, share control inputs and run in lockstep.
module tb_dot_product_mac;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        start, in_valid, out_ready;
  logic [3:0]  m_u, p_u;
  logic [7:0]  m_s, p_s;
  logic        in_ready_u, out_valid_u, busy_u, overflow_u;
  logic        in_ready_s, out_valid_s, busy_s, overflow_s;
  logic [7:0]  o_u;
  logic [15:0] o_s;

  int checks = 0;
  int errors = 0;
  int cyc, lat_u, lat_s;
  int a_u[3], b_u[3], a_s[3], b_s[3];

  always #5 CLOCK = ~CLOCK;

  dot_product_mac #(.W(4), .LEN(3), .OW(8), .SIGNED(0)) u_uns (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_u), .m(m_u), .p(p_u), .out_valid(out_valid_u),
    .out_ready(out_ready), .o(o_u), .busy(busy_u), .overflow(overflow_u)
  );

  dot_product_mac #(.W(8), .LEN(3), .OW(16), .SIGNED(1)) u_sgn (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_s), .m(m_s), .p(p_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .o(o_s), .busy(busy_s), .overflow(overflow_s)
  );

  // Reference: running sum clamped after every addition, flag sticky.
  function automatic int model_u(output bit ov);
    longint acc = 0;
    ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc += longint'(a_u[i]) * longint'(b_u[i]);
      if (acc > 255) begin acc = 255; ov = 1'b1; end
    end
    return int'(acc);
  endfunction

  function automatic int model_s(output bit ov);
    longint acc = 0;
    ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc += longint'(a_s[i]) * longint'(b_s[i]);
      if (acc > 32767)  begin acc = 32767;  ov = 1'b1; end
      if (acc < -32768) begin acc = -32768; ov = 1'b1; end
    end
    return int'(acc);
  endfunction

  task automatic tick();
    @(posedge CLOCK); #1;
    cyc++;
    if (out_valid_u && lat_u < 0) lat_u = cyc;
    if (out_valid_s && lat_s < 0) lat_s = cyc;
  endtask

  // Start at edge 0, feed the three pairs with `gap` bubbles before element 2,
  // and record the edge after which each out_valid first rises (-1 if never).
  task automatic run_dot(input int gap);
    start = 1'b1;
    @(posedge CLOCK); #1;
    start = 1'b0;
    cyc = 0; lat_u = -1; lat_s = -1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
      in_valid = 1'b1;
      m_u = a_u[i][3:0]; p_u = b_u[i][3:0];
      m_s = a_s[i][7:0]; p_s = b_s[i][7:0];
      tick();
    end
    in_valid = 1'b0;
    while ((lat_u < 0 || lat_s < 0) && cyc < 40) tick();
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic set_ref_vectors();
    a_u = '{3, 4, 5};  b_u = '{6, 7, 8};
    a_s = '{-3, 4, 5}; b_s = '{6, -7, 8};
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_u = '0; p_u = '0; m_s = '0; p_s = '0;
    #2;
    checks++;
    if ({in_ready_u, out_valid_u, busy_u, overflow_u, o_u} !== 12'h000) begin
      errors++;
      $display("FAIL reset_u: got %b expected 0",
               {in_ready_u, out_valid_u, busy_u, overflow_u, o_u});
    end
    checks++;
    if ({in_ready_s, out_valid_s, busy_s, overflow_s, o_s} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_s: got %b expected 0",
               {in_ready_s, out_valid_s, busy_s, overflow_s, o_s});
    end
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_ref_vectors();
    run_dot(0);
    checks++;
    if (o_u !== 8'd86) begin errors++; $display("FAIL basic_o_u: got %0d expected 86", o_u); end
    checks++;
    if (lat_u != 5) begin errors++; $display("FAIL basic_lat: got %0d expected 5", lat_u); end
    checks++;
    if (overflow_u !== 1'b0) begin errors++; $display("FAIL basic_ovf_u: got %b expected 0", overflow_u); end
    checks++;
    if (o_s !== 16'hFFFA) begin errors++; $display("FAIL basic_o_s: got %h expected fffa", o_s); end
    checks++;
    if (overflow_s !== 1'b0) begin errors++; $display("FAIL basic_ovf_s: got %b expected 0", overflow_s); end
    checks++;
    if (in_ready_u !== 1'b0 || busy_u !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_flags: got in_ready=%b busy=%b expected 0/1", in_ready_u, busy_u);
    end
    consume();
    checks++;
    if (out_valid_u !== 1'b0 || busy_u !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got out_valid=%b busy=%b expected 0/0", out_valid_u, busy_u);
    end
  endtask

  task automatic test_bubble();
    set_ref_vectors();
    run_dot(2);
    checks++;
    if (lat_u != 7) begin errors++; $display("FAIL bubble_lat: got %0d expected 7", lat_u); end
    checks++;
    if (o_u !== 8'd86) begin errors++; $display("FAIL bubble_o_u: got %0d expected 86", o_u); end
    checks++;
    if (o_s !== 16'hFFFA) begin errors++; $display("FAIL bubble_o_s: got %h expected fffa", o_s); end
    consume();
  endtask

  task automatic test_saturate();
    a_u = '{15, 15, 15};       b_u = '{15, 15, 15};
    a_s = '{-128, -128, -128}; b_s = '{127, 127, 127};
    run_dot(0);
    checks++;
    if (o_u !== 8'd255 || overflow_u !== 1'b1) begin
      errors++;
      $display("FAIL sat_u: got o=%0d ovf=%b expected 255/1", o_u, overflow_u);
    end
    checks++;
    if (o_s !== 16'h8000 || overflow_s !== 1'b1) begin
      errors++;
      $display("FAIL sat_s: got o=%h ovf=%b expected 8000/1", o_s, overflow_s);
    end
    repeat (3) tick();
    consume();
    checks++;
    if (overflow_u !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", overflow_u); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (overflow_u !== 1'b0 || o_u !== 8'd0 || in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL sat_clear: got ovf=%b o=%0d in_ready=%b expected 0/0/1",
               overflow_u, o_u, in_ready_u);
    end
    in_valid = 1'b1; m_u = '0; p_u = '0; m_s = '0; p_s = '0;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (out_valid_u !== 1'b1 || o_u !== 8'd0 || overflow_u !== 1'b0) begin
      errors++;
      $display("FAIL sat_zero_run: got valid=%b o=%0d ovf=%b expected 1/0/0",
               out_valid_u, o_u, overflow_u);
    end
    consume();
  endtask

  task automatic test_done_hold();
    int exp_u, exp_s;
    bit ov;
    for (int i = 0; i < 3; i++) begin
      a_u[i] = $urandom_range(0, 15);       b_u[i] = $urandom_range(0, 15);
      a_s[i] = $urandom_range(0, 255) - 128; b_s[i] = $urandom_range(0, 255) - 128;
    end
    exp_u = model_u(ov);
    exp_s = model_s(ov);
    run_dot(0);
    for (int k = 0; k < 5; k++) begin
      start = (k % 2 == 0);
      tick();
      checks++;
      if (out_valid_u !== 1'b1 || o_u !== 8'(exp_u) || busy_u !== 1'b1 ||
          out_valid_s !== 1'b1 || o_s !== 16'(exp_s)) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b o_u=%0d busy=%b o_s=%h expected 1/%0d/1/%h",
                 k, out_valid_u, o_u, busy_u, o_s, 8'(exp_u), 16'(exp_s));
      end
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    checks++;
    if (busy_u !== 1'b0 || out_valid_u !== 1'b0) begin
      errors++;
      $display("FAIL hold_exit: got busy=%b valid=%b expected 0/0", busy_u, out_valid_u);
    end
    tick();
    checks++;
    if (busy_u !== 1'b0 || in_ready_u !== 1'b0) begin
      errors++;
      $display("FAIL hold_start_ignored: got busy=%b in_ready=%b expected 0/0", busy_u, in_ready_u);
    end
  endtask

  task automatic test_reset_mid();
    bit ov;
    int exp_u, exp_s;
    set_ref_vectors();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      m_u = a_u[i][3:0]; p_u = b_u[i][3:0]; m_s = a_s[i][7:0]; p_s = b_s[i][7:0];
      tick();
    end
    in_valid = 1'b0;
    #1 RESET_N = 1'b0;
    #1;
    checks++;
    if ({in_ready_u, out_valid_u, busy_u, overflow_u, o_u, busy_s, o_s} !== 29'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b expected 0",
               {in_ready_u, out_valid_u, busy_u, overflow_u, o_u, busy_s, o_s});
    end
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    a_u = '{1, 2, 3}; b_u = '{4, 5, 6};
    a_s = '{7, -8, 9}; b_s = '{-10, 11, 12};
    exp_u = model_u(ov);
    exp_s = model_s(ov);
    run_dot(0);
    checks++;
    if (o_u !== 8'(exp_u) || o_s !== 16'(exp_s) || lat_u != 5) begin
      errors++;
      $display("FAIL midreset_fresh: got o_u=%0d o_s=%h lat=%0d expected %0d/%h/5",
               o_u, o_s, lat_u, 8'(exp_u), 16'(exp_s));
    end
    consume();
  endtask

  task automatic test_random();
    int exp_u, exp_s, gap;
    bit ov_u, ov_s;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 3; i++) begin
        a_u[i] = $urandom_range(0, 15);        b_u[i] = $urandom_range(0, 15);
        a_s[i] = $urandom_range(0, 255) - 128; b_s[i] = $urandom_range(0, 255) - 128;
      end
      gap = $urandom_range(0, 3);
      exp_u = model_u(ov_u);
      exp_s = model_s(ov_s);
      run_dot(gap);
      checks++;
      if (o_u !== 8'(exp_u) || overflow_u !== ov_u) begin
        errors++;
        $display("FAIL rand_u_%0d: got o=%0d ovf=%b expected %0d/%b", n, o_u, overflow_u,
                 8'(exp_u), ov_u);
      end
      checks++;
      if (o_s !== 16'(exp_s) || overflow_s !== ov_s) begin
        errors++;
        $display("FAIL rand_s_%0d: got o=%h ovf=%b expected %h/%b", n, o_s, overflow_s,
                 16'(exp_s), ov_s);
      end
      checks++;
      if (lat_u != 5 + gap || lat_s != 5 + gap) begin
        errors++;
        $display("FAIL rand_lat_%0d: got %0d/%0d expected %0d", n, lat_u, lat_s, 5 + gap);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_saturate();
    test_done_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
